pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_if.sv | 41 ++++
 rtl/pipe_ctrl.sv | 132 +++++++++++++
 tb/tb_pipe_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Bundle of the pipeline-control handshake: hazard/event inputs and stage controls.
interface pipe_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned REG_WIDTH  = 5
);
  logic                  i_ifu_busy;
  logic                  i_lsu_busy;
  logic                  i_exu_jmp_en;
  logic [ADDR_WIDTH-1:0] i_exu_jmp_pc;
  logic                  i_exu_load;
  logic [REG_WIDTH-1:0]  i_exu_rd_addr;
  logic                  i_idu_rs1_en;
  logic                  i_idu_rs2_en;
  logic [REG_WIDTH-1:0]  i_idu_rs1_addr;
  logic [REG_WIDTH-1:0]  i_idu_rs2_addr;
  logic                  o_if2id_ready;
  logic                  o_id2ex_ready;
  logic                  o_ex2ma_ready;
  logic                  o_ma2wb_ready;
  logic                  o_if2id_flush;
  logic                  o_id2ex_flush;
  logic                  o_pc_redirect_en;
  logic [ADDR_WIDTH-1:0] o_pc_redirect_pc;
  logic [31:0]           o_stall_cnt;

  // Pipeline side: raises events, consumes stage controls.
  modport master (
    output i_ifu_busy, i_lsu_busy, i_exu_jmp_en, i_exu_jmp_pc, i_exu_load,
           i_exu_rd_addr, i_idu_rs1_en, i_idu_rs2_en, i_idu_rs1_addr, i_idu_rs2_addr,
    input  o_if2id_ready, o_id2ex_ready, o_ex2ma_ready, o_ma2wb_ready,
           o_if2id_flush, o_id2ex_flush, o_pc_redirect_en, o_pc_redirect_pc, o_stall_cnt
  );

  // Controller side.
  modport slave (
    input  i_ifu_busy, i_lsu_busy, i_exu_jmp_en, i_exu_jmp_pc, i_exu_load,
           i_exu_rd_addr, i_idu_rs1_en, i_idu_rs2_en, i_idu_rs1_addr, i_idu_rs2_addr,
    output o_if2id_ready, o_id2ex_ready, o_ex2ma_ready, o_ma2wb_ready,
           o_if2id_flush, o_id2ex_flush, o_pc_redirect_en, o_pc_redirect_pc, o_stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline controller: stalls, bubbles, flushes and PC redirect.
module pipe_ctrl #(
  parameter int unsigned          ADDR_WIDTH = 32,
  parameter int unsigned          REG_WIDTH  = 5,
  parameter logic [ADDR_WIDTH-1:0] ADDR_INIT = ADDR_WIDTH'(32'h8000_0000)
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst,
  input  logic                  i_ifu_busy,
  input  logic                  i_lsu_busy,
  input  logic                  i_exu_jmp_en,
  input  logic [ADDR_WIDTH-1:0] i_exu_jmp_pc,
  input  logic                  i_exu_load,
  input  logic [REG_WIDTH-1:0]  i_exu_rd_addr,
  input  logic                  i_idu_rs1_en,
  input  logic                  i_idu_rs2_en,
  input  logic [REG_WIDTH-1:0]  i_idu_rs1_addr,
  input  logic [REG_WIDTH-1:0]  i_idu_rs2_addr,
  output logic                  o_if2id_ready,
  output logic                  o_id2ex_ready,
  output logic                  o_ex2ma_ready,
  output logic                  o_ma2wb_ready,
  output logic                  o_if2id_flush,
  output logic                  o_id2ex_flush,
  output logic                  o_pc_redirect_en,
  output logic [ADDR_WIDTH-1:0] o_pc_redirect_pc,
  output logic [31:0]           o_stall_cnt
);

  localparam int unsigned CNT_WIDTH = 32;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_redirect_en;
  logic [ADDR_WIDTH-1:0] r_redirect_pc;
  logic [CNT_WIDTH-1:0]  r_stall_cnt;
  logic                  w_hazard;
  logic                  w_run_eval;
  logic                  w_take_jmp;

  // Load-use hazard: EX load writes a register that ID is about to read.
  always_comb begin
    w_hazard = i_exu_load && (i_exu_rd_addr != '0) &&
               ((i_idu_rs1_en && (i_idu_rs1_addr == i_exu_rd_addr)) ||
                (i_idu_rs2_en && (i_idu_rs2_addr == i_exu_rd_addr)));
  end

  // Next state and stage controls; MEM_WAIT falls through to RUN evaluation once memory is done.
  always_comb begin
    w_state_nxt   = r_state;
    w_take_jmp    = 1'b0;
    o_if2id_ready = 1'b1;
    o_id2ex_ready = 1'b1;
    o_ex2ma_ready = 1'b1;
    o_ma2wb_ready = 1'b1;
    o_if2id_flush = 1'b0;
    o_id2ex_flush = 1'b0;
    w_run_eval    = (r_state == RUN) || ((r_state == MEM_WAIT) && !i_lsu_busy);

    if (r_state == REDIRECT) begin
      // Jumps seen here are deferred to the next RUN cycle.
      o_if2id_flush = 1'b1;
      w_state_nxt   = RUN;
    end else if (r_state == MEM_WAIT && i_lsu_busy) begin
      o_if2id_ready = 1'b0;
      o_id2ex_ready = 1'b0;
      o_ex2ma_ready = 1'b0;
      o_ma2wb_ready = 1'b0;
    end else if (w_run_eval) begin
      w_state_nxt = RUN;
      if (i_lsu_busy) begin
        o_if2id_ready = 1'b0;
        o_id2ex_ready = 1'b0;
        o_ex2ma_ready = 1'b0;
        o_ma2wb_ready = 1'b0;
        w_state_nxt   = MEM_WAIT;
      end else if (i_exu_jmp_en) begin
        o_if2id_flush = 1'b1;
        o_id2ex_flush = 1'b1;
        w_take_jmp    = 1'b1;
        w_state_nxt   = REDIRECT;
      end else if (w_hazard) begin
        o_if2id_ready = 1'b0;
        o_id2ex_flush = 1'b1;
      end else if (i_ifu_busy) begin
        o_if2id_flush = 1'b1;
      end
    end

    // Reset holds every stage and fills with bubbles.
    if (i_sys_rst) begin
      o_if2id_ready = 1'b0;
      o_id2ex_ready = 1'b0;
      o_ex2ma_ready = 1'b0;
      o_ma2wb_ready = 1'b0;
      o_if2id_flush = 1'b1;
      o_id2ex_flush = 1'b1;
      w_take_jmp    = 1'b0;
      w_state_nxt   = RUN;
    end
  end

  // State, redirect pulse/target and saturating stall counter.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_state       <= RUN;
      r_redirect_en <= 1'b0;
      r_redirect_pc <= ADDR_INIT;
      r_stall_cnt   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_redirect_en <= w_take_jmp;
      if (w_take_jmp) begin
        r_redirect_pc <= i_exu_jmp_pc;
      end
      if (!o_if2id_ready && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign o_pc_redirect_en = r_redirect_en;
  assign o_pc_redirect_pc = r_redirect_pc;
  assign o_stall_cnt      = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: vector table for RUN decisions plus multi-cycle sequences.
module tb_pipe_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [31:0] exp_cnt;

  pipe_ctrl_if #(.ADDR_WIDTH(32), .REG_WIDTH(5)) bus ();

  pipe_ctrl dut (
    .i_sys_clk        (clk),
    .i_sys_rst        (rst),
    .i_ifu_busy       (bus.i_ifu_busy),
    .i_lsu_busy       (bus.i_lsu_busy),
    .i_exu_jmp_en     (bus.i_exu_jmp_en),
    .i_exu_jmp_pc     (bus.i_exu_jmp_pc),
    .i_exu_load       (bus.i_exu_load),
    .i_exu_rd_addr    (bus.i_exu_rd_addr),
    .i_idu_rs1_en     (bus.i_idu_rs1_en),
    .i_idu_rs2_en     (bus.i_idu_rs2_en),
    .i_idu_rs1_addr   (bus.i_idu_rs1_addr),
    .i_idu_rs2_addr   (bus.i_idu_rs2_addr),
    .o_if2id_ready    (bus.o_if2id_ready),
    .o_id2ex_ready    (bus.o_id2ex_ready),
    .o_ex2ma_ready    (bus.o_ex2ma_ready),
    .o_ma2wb_ready    (bus.o_ma2wb_ready),
    .o_if2id_flush    (bus.o_if2id_flush),
    .o_id2ex_flush    (bus.o_id2ex_flush),
    .o_pc_redirect_en (bus.o_pc_redirect_en),
    .o_pc_redirect_pc (bus.o_pc_redirect_pc),
    .o_stall_cnt      (bus.o_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       ifu;
    logic       load;
    logic [4:0] rd;
    logic       r1e;
    logic [4:0] r1;
    logic       r2e;
    logic [4:0] r2;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [5:0] ctl();
    return {bus.o_if2id_ready, bus.o_id2ex_ready, bus.o_ex2ma_ready,
            bus.o_ma2wb_ready, bus.o_if2id_flush, bus.o_id2ex_flush};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ifu, input logic lsu, input logic jmp, input logic [31:0] pc,
                       input logic load, input logic [4:0] rd, input logic r1e,
                       input logic [4:0] r1, input logic r2e, input logic [4:0] r2);
    bus.i_ifu_busy     = ifu;
    bus.i_lsu_busy     = lsu;
    bus.i_exu_jmp_en   = jmp;
    bus.i_exu_jmp_pc   = pc;
    bus.i_exu_load     = load;
    bus.i_exu_rd_addr  = rd;
    bus.i_idu_rs1_en   = r1e;
    bus.i_idu_rs1_addr = r1;
    bus.i_idu_rs2_en   = r2e;
    bus.i_idu_rs2_addr = r2;
  endtask

  task automatic idle();
    drive(0, 0, 0, 32'h0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    #1;
    chk("reset_ctl", 32'(ctl()), 32'(6'b0000_11));
    @(negedge clk);
    rst = 1'b0;
    chk("reset_redir_en", 32'(bus.o_pc_redirect_en), 32'd0);
    chk("reset_redir_pc", bus.o_pc_redirect_pc, 32'h8000_0000);
    chk("reset_cnt", bus.o_stall_cnt, 32'd0);
    exp_cnt = 32'd0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_cnt = 0;
    rst = 1'b1;
    idle();

    //            ifu load rd    r1e r1    r2e r2    expected {rdy x4, flush x2}
    vecs[0] = '{1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  6'b1111_00};
    vecs[1] = '{1'b0, 1'b1, 5'd5,  1'b1, 5'd5,  1'b0, 5'd0,  6'b0111_01};
    vecs[2] = '{1'b0, 1'b1, 5'd5,  1'b1, 5'd3,  1'b1, 5'd5,  6'b0111_01};
    vecs[3] = '{1'b0, 1'b1, 5'd0,  1'b1, 5'd0,  1'b1, 5'd0,  6'b1111_00};
    vecs[4] = '{1'b0, 1'b1, 5'd5,  1'b0, 5'd5,  1'b1, 5'd4,  6'b1111_00};
    vecs[5] = '{1'b0, 1'b0, 5'd5,  1'b1, 5'd5,  1'b1, 5'd5,  6'b1111_00};
    vecs[6] = '{1'b1, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  6'b1111_10};
    vecs[7] = '{1'b1, 1'b1, 5'd7,  1'b0, 5'd0,  1'b1, 5'd7,  6'b0111_01};
    vecs[8] = '{1'b0, 1'b1, 5'd31, 1'b0, 5'd0,  1'b1, 5'd31, 6'b0111_01};

    do_reset();

    // Idle flow.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      idle();
      #1;
      chk("idle_ctl", 32'(ctl()), 32'(6'b1111_00));
    end
    @(negedge clk);
    chk("idle_cnt", bus.o_stall_cnt, 32'd0);

    // RUN-state decision table; each hazard vector is a one-cycle bubble.
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].ifu, 0, 0, 32'h0, vecs[i].load, vecs[i].rd,
            vecs[i].r1e, vecs[i].r1, vecs[i].r2e, vecs[i].r2);
      #1;
      chk($sformatf("vec%0d_ctl", i), 32'(ctl()), 32'(vecs[i].exp));
      if (!vecs[i].exp[5]) exp_cnt = exp_cnt + 32'd1;
      @(negedge clk);
      chk($sformatf("vec%0d_cnt", i), bus.o_stall_cnt, exp_cnt);
      chk($sformatf("vec%0d_redir", i), 32'(bus.o_pc_redirect_en), 32'd0);
    end
    idle();

    // Redirect: flush at T, pulse at T+1 only.
    drive(0, 0, 1, 32'h8000_0040, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    #1;
    chk("jmp_T_ctl", 32'(ctl()), 32'(6'b1111_11));
    chk("jmp_T_redir", 32'(bus.o_pc_redirect_en), 32'd0);
    @(negedge clk);
    idle();
    #1;
    chk("jmp_T1_redir", 32'(bus.o_pc_redirect_en), 32'd1);
    chk("jmp_T1_pc", bus.o_pc_redirect_pc, 32'h8000_0040);
    chk("jmp_T1_ctl", 32'(ctl()), 32'(6'b1111_10));
    @(negedge clk);
    #1;
    chk("jmp_T2_redir", 32'(bus.o_pc_redirect_en), 32'd0);
    chk("jmp_T2_ctl", 32'(ctl()), 32'(6'b1111_00));

    // Memory wait with a pending jump that must wait for memory.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 32'h8000_0080, 0, 5'd0, 0, 5'd0, 0, 5'd0);
      #1;
      chk("mw_ctl", 32'(ctl()), 32'(6'b0000_00));
      chk("mw_redir", 32'(bus.o_pc_redirect_en), 32'd0);
      @(negedge clk);
    end
    drive(0, 0, 1, 32'h8000_0080, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    #1;
    chk("mw_exit_ctl", 32'(ctl()), 32'(6'b1111_11));
    @(negedge clk);
    idle();
    #1;
    chk("mw_redir_en", 32'(bus.o_pc_redirect_en), 32'd1);
    chk("mw_redir_pc", bus.o_pc_redirect_pc, 32'h8000_0080);
    chk("mw_redir_ctl", 32'(ctl()), 32'(6'b1111_10));
    chk("mw_cnt", bus.o_stall_cnt, 32'd3);

    // Jump arriving during REDIRECT is taken on the following RUN cycle.
    @(negedge clk);
    drive(0, 0, 1, 32'h8000_0100, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    @(negedge clk);
    drive(0, 0, 1, 32'h8000_0200, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    #1;
    chk("jj_T1_ctl", 32'(ctl()), 32'(6'b1111_10));
    chk("jj_T1_pc", bus.o_pc_redirect_pc, 32'h8000_0100);
    @(negedge clk);
    #1;
    chk("jj_T2_ctl", 32'(ctl()), 32'(6'b1111_11));
    chk("jj_T2_redir", 32'(bus.o_pc_redirect_en), 32'd0);
    @(negedge clk);
    idle();
    #1;
    chk("jj_T3_redir", 32'(bus.o_pc_redirect_en), 32'd1);
    chk("jj_T3_pc", bus.o_pc_redirect_pc, 32'h8000_0200);

    // Reset during REDIRECT aborts the redirect.
    @(negedge clk);
    drive(0, 0, 1, 32'h8000_0300, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    @(negedge clk);
    idle();
    rst = 1'b1;
    #1;
    chk("mr_ctl", 32'(ctl()), 32'(6'b0000_11));
    @(negedge clk);
    rst = 1'b0;
    chk("mr_redir_en", 32'(bus.o_pc_redirect_en), 32'd0);
    chk("mr_redir_pc", bus.o_pc_redirect_pc, 32'h8000_0000);
    @(negedge clk);
    chk("mr_redir_en2", 32'(bus.o_pc_redirect_en), 32'd0);
    chk("mr_ctl2", 32'(ctl()), 32'(6'b1111_00));

    // Stall counter saturation.
    force dut.r_stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_stall_cnt;
    #1;
    chk("sat_preset", bus.o_stall_cnt, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(0, 0, 0, 32'h0, 1, 5'd9, 1, 5'd9, 0, 5'd0);
      #1;
      chk("sat_ctl", 32'(ctl()), 32'(6'b0111_01));
    end
    @(negedge clk);
    idle();
    chk("sat_cnt", bus.o_stall_cnt, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("sat_hold", bus.o_stall_cnt, 32'hFFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
